// File: rtl/fp16_pkg.sv
// rtl/fp16_pkg.sv - shared widths, constants and FSM states for the fp16 aligner
package fp16_pkg;

  localparam int EXP_W  = 5;
  localparam int FRAC_W = 10;
  localparam int ALN_W  = FRAC_W + 4;

  localparam logic [EXP_W-1:0] EXP_SPECIAL = {EXP_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMP,
    ST_SHIFT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/fp16_exp_compare.sv
// rtl/fp16_exp_compare.sv - effective exponent magnitude difference and swap flag
module fp16_exp_compare #(
  parameter int EXP_W = fp16_pkg::EXP_W
) (
  input  logic [EXP_W-1:0] ea_eff,
  input  logic [EXP_W-1:0] eb_eff,
  output logic [EXP_W-1:0] diff,
  output logic             swap
);

  // Ties keep A as the larger operand, so swap needs a strict compare.
  always_comb begin
    swap = (eb_eff > ea_eff);
    diff = swap ? (eb_eff - ea_eff) : (ea_eff - eb_eff);
  end

endmodule

// File: rtl/fp16_align_sequencer.sv
// rtl/fp16_align_sequencer.sv - sequential exponent compare and mantissa alignment of two fp16 operands
module fp16_align_sequencer #(
  parameter int EXP_W  = fp16_pkg::EXP_W,
  parameter int FRAC_W = fp16_pkg::FRAC_W,
  parameter int ALN_W  = FRAC_W + 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EXP_W-1:0] out_exp,
  output logic [ALN_W-1:0] out_man_big,
  output logic [ALN_W-1:0] out_man_small,
  output logic             out_sign_big,
  output logic             out_sign_small,
  output logic             out_swap,
  output logic             out_special
);
  import fp16_pkg::*;

  localparam int K_W    = $clog2(ALN_W + 1);
  localparam int SIGN_B = EXP_W + FRAC_W;

  state_t state, state_n;

  logic [15:0]      a_q, b_q;
  logic [K_W-1:0]   k_q, k_c;
  logic             sa, sb;
  logic [EXP_W-1:0] ea_raw, eb_raw, ea_eff, eb_eff, diff;
  logic [ALN_W-1:0] man_a, man_b, man_shift;
  logic             swap_c, special_c;

  // Operand decode; denormals use effective exponent 1 with no hidden bit.
  always_comb begin
    sa        = a_q[SIGN_B];
    sb        = b_q[SIGN_B];
    ea_raw    = a_q[SIGN_B-1:FRAC_W];
    eb_raw    = b_q[SIGN_B-1:FRAC_W];
    ea_eff    = (ea_raw == '0) ? EXP_W'(1) : ea_raw;
    eb_eff    = (eb_raw == '0) ? EXP_W'(1) : eb_raw;
    man_a     = {(ea_raw != '0), a_q[FRAC_W-1:0], 3'b000};
    man_b     = {(eb_raw != '0), b_q[FRAC_W-1:0], 3'b000};
    special_c = (ea_raw == EXP_SPECIAL) || (eb_raw == EXP_SPECIAL);
    k_c       = (int'(diff) > ALN_W) ? K_W'(ALN_W) : K_W'(diff);
    man_shift = {1'b0, out_man_small[ALN_W-1:2], out_man_small[1] | out_man_small[0]};
  end

  fp16_exp_compare #(
    .EXP_W (EXP_W)
  ) u_exp_compare (
    .ea_eff (ea_eff),
    .eb_eff (eb_eff),
    .diff   (diff),
    .swap   (swap_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_n = ST_CMP;
      end
      ST_CMP: begin
        if (special_c || (k_c == '0)) state_n = ST_DONE;
        else                          state_n = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (k_q == K_W'(1)) state_n = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Result registers only move in CMP and SHIFT, so they stay frozen through DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q            <= '0;
      b_q            <= '0;
      k_q            <= '0;
      out_exp        <= '0;
      out_man_big    <= '0;
      out_man_small  <= '0;
      out_sign_big   <= 1'b0;
      out_sign_small <= 1'b0;
      out_swap       <= 1'b0;
      out_special    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_q <= in_a;
            b_q <= in_b;
          end
        end
        ST_CMP: begin
          k_q            <= k_c;
          out_swap       <= swap_c;
          out_special    <= special_c;
          out_exp        <= swap_c ? eb_raw : ea_raw;
          out_man_big    <= swap_c ? man_b : man_a;
          out_man_small  <= swap_c ? man_a : man_b;
          out_sign_big   <= swap_c ? sb : sa;
          out_sign_small <= swap_c ? sa : sb;
        end
        ST_SHIFT: begin
          out_man_small <= man_shift;
          k_q           <= k_q - K_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp16_align_sequencer.sv
// tb/tb_fp16_align_sequencer.sv - directed self-checking bench for fp16_align_sequencer
module tb_fp16_align_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a, in_b;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_exp;
  logic [13:0] out_man_big, out_man_small;
  logic        out_sign_big, out_sign_small, out_swap, out_special;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fp16_align_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_a           (in_a),
    .in_b           (in_b),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_exp        (out_exp),
    .out_man_big    (out_man_big),
    .out_man_small  (out_man_small),
    .out_sign_big   (out_sign_big),
    .out_sign_small (out_sign_small),
    .out_swap       (out_swap),
    .out_special    (out_special)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Handshake one operand pair, then count edges until out_valid.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input int lat);
    int n;
    chk({tag, "_in_ready"}, in_ready, 1);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_latency"}, n, lat);
  endtask

  task automatic finish_op(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_drain_valid"}, out_valid, 0);
    chk({tag, "_drain_ready"}, in_ready, 1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_exp", out_exp, 0);
    chk("rst_man_big", out_man_big, 0);
    chk("rst_man_small", out_man_small, 0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);

    // k=1 alignment
    run_op("t027", 16'h3C00, 16'h3800, 2);
    chk("t027_exp", out_exp, 5'h0F);
    chk("t027_man_big", out_man_big, 14'h2000);
    chk("t027_man_small", out_man_small, 14'h1000);
    chk("t027_swap", out_swap, 0);
    chk("t027_special", out_special, 0);
    finish_op("t027");
    chk("t027_hold_after", out_man_small, 14'h1000);

    // equal exponents, opposite signs
    run_op("t028", 16'h3C00, 16'hBC00, 1);
    chk("t028_swap", out_swap, 0);
    chk("t028_sign_big", out_sign_big, 0);
    chk("t028_sign_small", out_sign_small, 1);
    chk("t028_man_big", out_man_big, 14'h2000);
    chk("t028_man_small", out_man_small, 14'h2000);
    finish_op("t028");

    // clamped shift of a denormal to sticky only
    run_op("t029", 16'h0001, 16'h7BFF, 15);
    chk("t029_swap", out_swap, 1);
    chk("t029_exp", out_exp, 5'h1E);
    chk("t029_man_big", out_man_big, 14'h3FF8);
    chk("t029_man_small", out_man_small, 14'h0001);
    chk("t029_sign_small", out_sign_small, 0);
    finish_op("t029");

    // infinity operand skips shifting
    run_op("t030", 16'h7C00, 16'h3C00, 1);
    chk("t030_special", out_special, 1);
    chk("t030_exp", out_exp, 5'h1F);
    chk("t030_man_small", out_man_small, 14'h2000);
    chk("t030_swap", out_swap, 0);
    finish_op("t030");

    // back-pressure in DONE with a new pair waiting
    run_op("t031", 16'h3800, 16'h3C00, 2);
    chk("t031_swap", out_swap, 1);
    in_valid = 1'b1;
    in_a     = 16'h4000;
    in_b     = 16'h3C00;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("t031_bp_valid", out_valid, 1);
      chk("t031_bp_ready", in_ready, 0);
      chk("t031_bp_man_small", out_man_small, 14'h1000);
      chk("t031_bp_exp", out_exp, 5'h0F);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("t031_no_accept_valid", out_valid, 0);
    chk("t031_idle_ready", in_ready, 1);
    chk("t031_no_accept_swap", out_swap, 1);
    run_op("t031b", 16'h4000, 16'h3C00, 2);
    chk("t031b_exp", out_exp, 5'h10);
    chk("t031b_swap", out_swap, 0);
    chk("t031b_man_small", out_man_small, 14'h1000);
    finish_op("t031b");

    // reset in the middle of SHIFT
    in_valid = 1'b1;
    in_a     = 16'h0001;
    in_b     = 16'h7BFF;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("t032_mid_valid", out_valid, 0);
    chk("t032_mid_man_big", out_man_big, 14'h3FF8);
    chk("t032_mid_man_small", out_man_small, 14'h0001);
    rst_n = 1'b0;
    #1;
    chk("t032_rst_valid", out_valid, 0);
    chk("t032_rst_man_big", out_man_big, 0);
    chk("t032_rst_exp", out_exp, 0);
    chk("t032_rst_swap", out_swap, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_op("t032b", 16'h3C00, 16'h3800, 2);
    chk("t032b_exp", out_exp, 5'h0F);
    chk("t032b_man_big", out_man_big, 14'h2000);
    chk("t032b_man_small", out_man_small, 14'h1000);
    finish_op("t032b");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
